// File: rtl/referee_mux.sv
`default_nettype none
// ============================================================================
// Module   : referee_mux
// Brief    : Pops lines from N_IN emissor FIFOs and routes each one to the
//            receptor FIFO selected by its class field. Lines whose class has
//            no receptor are counted in drop_cnt. Define REFEREE_MUX_RR_EN for
//            round-robin arbitration; otherwise the lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module referee_mux #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int LINE_SIZE  = 12,
    parameter int CLASS_BITS = 2,
    parameter int IDX_BITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                state,
    input  logic [N_IN-1:0]           empty_f,
    input  logic [N_IN*LINE_SIZE-1:0] data_in,
    input  logic [N_OUT-1:0]          almost_full,
    output logic [N_IN-1:0]           pop,
    output logic [N_OUT-1:0]          push,
    output logic [LINE_SIZE-1:0]      data_out,
    output logic [IDX_BITS-1:0]       grant_id,
    output logic [7:0]                drop_cnt
);

    localparam logic [3:0] c_ST_ACTIVE = 4'b1000;
    localparam logic [7:0] c_DROP_MAX  = 8'hFF;

    logic [N_IN-1:0]       r_pop;
    logic [IDX_BITS-1:0]   r_pop_idx;
    logic                  r_s1_valid;
    logic [IDX_BITS-1:0]   r_s1_idx;
    logic [N_OUT-1:0]      r_push;
    logic [LINE_SIZE-1:0]  r_data_out;
    logic [IDX_BITS-1:0]   r_grant_id;
    logic [7:0]            r_drop_cnt;
    logic [IDX_BITS-1:0]   r_ptr;

    logic [N_IN-1:0]       w_elig;
    logic                  w_active;
    logic                  w_found;
    logic                  w_go;
    logic [IDX_BITS-1:0]   w_gnt_idx;
    logic [N_IN-1:0]       w_gnt_onehot;
    int                    w_cand;
    logic [LINE_SIZE-1:0]  w_line;
    logic [CLASS_BITS-1:0] w_class;
    logic [N_OUT-1:0]      w_push_dec;
    logic                  w_drop;

    // An input popped last cycle still shows a stale empty flag, so skip it.
    assign w_elig   = ~empty_f & ~r_pop;
    assign w_active = (state == c_ST_ACTIVE);

    // Search starts at r_ptr; with fixed priority r_ptr stays 0.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = 0;
        for (int k = 0; k < N_IN; k++) begin
            w_cand = (int'(r_ptr) + k) % N_IN;
            for (int i = 0; i < N_IN; i++) begin
                if (!w_found && (i == w_cand) && w_elig[i]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = IDX_BITS'(i);
                end
            end
        end
    end

    assign w_go         = w_active & ~(|almost_full) & w_found;
    assign w_gnt_onehot = {{(N_IN-1){1'b0}}, 1'b1} << w_gnt_idx;

    always_comb begin
        w_line = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(r_s1_idx) == i) begin
                w_line = data_in[i*LINE_SIZE +: LINE_SIZE];
            end
        end
    end

    assign w_class = w_line[LINE_SIZE-1 -: CLASS_BITS];

    always_comb begin
        w_push_dec = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (int'(w_class) == j) begin
                w_push_dec[j] = 1'b1;
            end
        end
    end

    assign w_drop = ~(|w_push_dec);

    // Pipeline: pop (T+1) -> FIFO data valid (T+2) -> push (T+3).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop      <= '0;
            r_pop_idx  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_push     <= '0;
            r_data_out <= '0;
            r_grant_id <= '0;
            r_drop_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            r_pop      <= w_go ? w_gnt_onehot : '0;
            r_pop_idx  <= w_gnt_idx;
            r_s1_valid <= |r_pop;
            r_s1_idx   <= r_pop_idx;
            r_push     <= r_s1_valid ? w_push_dec : '0;
            if (r_s1_valid) begin
                r_data_out <= w_line;
                r_grant_id <= r_s1_idx;
                if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
`ifdef REFEREE_MUX_RR_EN
            if (w_go) begin
                r_ptr <= IDX_BITS'((int'(w_gnt_idx) + 1) % N_IN);
            end
`else
            r_ptr <= '0;
`endif
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign data_out = r_data_out;
    assign grant_id = r_grant_id;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_referee_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_referee_mux
// Brief    : Scoreboard bench for referee_mux (N_IN=4, N_OUT=3) covering
//            reset, routing, arbitration order, back-pressure, state exit,
//            reset mid-transfer and drop counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_referee_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [3:0]  empty_f;
    logic [11:0] line [4];
    logic [47:0] data_in;
    logic [2:0]  almost_full;
    logic [3:0]  pop;
    logic [2:0]  push;
    logic [11:0] data_out;
    logic [1:0]  grant_id;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    assign data_in = {line[3], line[2], line[1], line[0]};

    referee_mux #(
        .N_IN       (4),
        .N_OUT      (3),
        .LINE_SIZE  (12),
        .CLASS_BITS (2),
        .IDX_BITS   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .empty_f     (empty_f),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .grant_id    (grant_id),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {int cyc; logic [3:0] pop;} pop_t;
    typedef struct {int cyc; logic [2:0] push; logic [11:0] data; logic [1:0] gid;} push_t;

    pop_t  pop_q[$];
    push_t push_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    mon_en = 1'b0;
    bit    track_pop = 1'b0;
    int    t0;
    int    seq [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop of input idx visible in cycle pc; its push follows two cycles later.
    task automatic expect_line(input int pc, input int idx);
        pop_t        p;
        push_t       q;
        logic [11:0] l;
        logic [1:0]  cls;
        l      = line[idx];
        cls    = l[11:10];
        p.cyc  = pc;
        p.pop  = 4'b0001 << idx;
        pop_q.push_back(p);
        if (cls != 2'b11) begin
            q.cyc  = pc + 2;
            q.push = 3'b001 << cls;
            q.data = l;
            q.gid  = idx[1:0];
            push_q.push_back(q);
        end
    endtask

    task automatic do_reset();
        state   = 4'b0000;
        empty_f = 4'b1111;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_en && track_pop && (pop !== 4'b0000)) begin : mon_pop
            pop_t e;
            checks++;
            if (pop_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %b at cycle %0d, none expected", pop, cyc);
            end else begin
                e = pop_q.pop_front();
                if ((e.pop !== pop) || (e.cyc != cyc)) begin
                    failures++;
                    $display("FAIL pop: got %b at cycle %0d expected %b at cycle %0d",
                             pop, cyc, e.pop, e.cyc);
                end
            end
        end
        if (mon_en && (push !== 3'b000)) begin : mon_push
            push_t e;
            checks++;
            if (push_q.size() == 0) begin
                failures++;
                $display("FAIL push_unexpected: got %b at cycle %0d, none expected", push, cyc);
            end else begin
                e = push_q.pop_front();
                if ((e.push !== push) || (e.cyc != cyc) || (e.data !== data_out) || (e.gid !== grant_id)) begin
                    failures++;
                    $display("FAIL push: got push=%b data=%h gid=%0d cycle=%0d expected push=%b data=%h gid=%0d cycle=%0d",
                             push, data_out, grant_id, cyc, e.push, e.data, e.gid, e.cyc);
                end
            end
        end
    end

    initial begin
        line[0]     = 12'h012;  // class 0
        line[1]     = 12'h434;  // class 1
        line[2]     = 12'hA5C;  // class 2
        line[3]     = 12'h3C7;  // class 0
        reset       = 1'b1;
        state       = 4'b1000;
        empty_f     = 4'b0000;
        almost_full = 3'b000;

        // Reset dominates an active controller with every input non-empty.
        tick(2);
        chk("reset_pop", 32'(pop), 32'h0);
        chk("reset_push", 32'(push), 32'h0);
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_grant_id", 32'(grant_id), 32'h0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
        do_reset();
        mon_en    = 1'b1;
        track_pop = 1'b1;

        // Single line from input 2, class 2.
        state   = 4'b1000;
        empty_f = 4'b1011;
        t0      = cyc;
        expect_line(t0 + 1, 2);
        tick();
        empty_f = 4'b1111;
        tick(4);
        chk("single_data_out", 32'(data_out), 32'hA5C);
        chk("single_grant_id", 32'(grant_id), 32'h2);

        // All inputs non-empty for 8 decision cycles.
        tick(2);
        do_reset();
`ifdef REFEREE_MUX_RR_EN
        seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
        seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        state   = 4'b1000;
        empty_f = 4'b0000;
        t0      = cyc;
        for (int k = 0; k < 8; k++) expect_line(t0 + 1 + k, seq[k]);
        tick(8);
        empty_f = 4'b1111;
        tick(4);

        // almost_full raised right after a pop blocks only new pops.
        do_reset();
        state   = 4'b1000;
        empty_f = 4'b1110;
        t0      = cyc;
        expect_line(t0 + 1, 0);
        expect_line(t0 + 5, 0);
        tick();
        almost_full = 3'b010;
        tick(3);
        almost_full = 3'b000;
        tick();
        empty_f = 4'b1111;
        tick(4);

        // Leaving ACTIVE one cycle after a pop.
        do_reset();
        state   = 4'b1000;
        empty_f = 4'b1110;
        t0      = cyc;
        expect_line(t0 + 1, 0);
        tick();
        state = 4'b0100;
        tick(4);
        chk("state_exit_grant_id", 32'(grant_id), 32'h0);
        chk("state_exit_data_out", 32'(data_out), 32'h012);

        // Reset while a line is in flight: popped, never pushed.
        do_reset();
        state   = 4'b1000;
        empty_f = 4'b1110;
        t0      = cyc;
        begin : inflight_pop
            pop_t p;
            p.cyc = t0 + 1;
            p.pop = 4'b0001;
            pop_q.push_back(p);
        end
        tick();
        reset   = 1'b1;
        empty_f = 4'b1111;
        tick();
        reset = 1'b0;
        state = 4'b0000;
        tick(4);
        chk("midreset_data_out", 32'(data_out), 32'h0);

        // Class 3 has no receptor when N_OUT=3.
        do_reset();
        line[2] = 12'hE01;
        line[3] = 12'hC55;
        chk("drop_start", 32'(drop_cnt), 32'h0);
        state   = 4'b1000;
        empty_f = 4'b0111;
        t0      = cyc;
        expect_line(t0 + 1, 3);
        tick();
        empty_f = 4'b1111;
        tick();
        chk("drop_before", 32'(drop_cnt), 32'h0);
        tick();
        chk("drop_one", 32'(drop_cnt), 32'h1);
        chk("drop_data_out", 32'(data_out), 32'hC55);
        chk("drop_grant_id", 32'(grant_id), 32'h3);
        tick(2);

        track_pop = 1'b0;
        empty_f   = 4'b0011;
        tick(100);
        empty_f = 4'b1111;
        tick(4);
        chk("drop_101", 32'(drop_cnt), 32'd101);
        empty_f = 4'b0011;
        tick(200);
        empty_f = 4'b1111;
        tick(4);
        chk("drop_saturate", 32'(drop_cnt), 32'd255);

        chk("pop_q_drained", 32'(pop_q.size()), 32'h0);
        chk("push_q_drained", 32'(push_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
